// File: rtl/breg_pkg.sv
// Shared types, default geometry and the address-to-region map used by the
// register-space decoder and the sequencer register block.
package breg_pkg;

  typedef enum logic [2:0] {IDLE, LATCH, STROBE, ACK, ERR} state_t;
  typedef enum logic [1:0] {LOCAL, FIFO, EXT, UNMAPPED} region_t;

  localparam int unsigned DEF_ADDR_W      = 9;
  localparam int unsigned DEF_NREG        = 16;
  localparam int unsigned DEF_EXT_BASE    = 32;
  localparam int unsigned DEF_EXT_SIZE    = 32;
  localparam int unsigned DEF_FIFO_BASE   = 60;
  localparam int unsigned DEF_WAIT_STATES = 3;
  localparam int unsigned DEF_TIMEOUT     = 255;
  localparam int unsigned FIFO_WORDS      = 4;

  // FIFO words sit inside the external window and must win over it.
  function automatic region_t region_of(input logic [31:0] addr,
                                        input int unsigned nreg,
                                        input int unsigned ext_base,
                                        input int unsigned ext_size,
                                        input int unsigned fifo_base);
    region_t r;
    if (addr >= fifo_base && addr < fifo_base + FIFO_WORDS)
      r = FIFO;
    else if (addr < nreg)
      r = LOCAL;
    else if (addr >= ext_base && addr < ext_base + ext_size)
      r = EXT;
    else
      r = UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/breg_region_dec.sv
// Combinational word-address decode into region and FIFO register index.
module breg_region_dec
  import breg_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned NREG      = DEF_NREG,
  parameter int unsigned EXT_BASE  = DEF_EXT_BASE,
  parameter int unsigned EXT_SIZE  = DEF_EXT_SIZE,
  parameter int unsigned FIFO_BASE = DEF_FIFO_BASE
) (
  input  logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic [1:0]        index
);

  assign region = region_of(32'(addr), NREG, EXT_BASE, EXT_SIZE, FIFO_BASE);
  assign index  = addr[1:0];

endmodule

// File: rtl/breg_decode_seq.sv
// Clocked register-space decoder: latches a bus-slave access, times the
// target strobe with a counter and requests DTACK or a bus error.
module breg_decode_seq
  import breg_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned NREG        = DEF_NREG,
  parameter int unsigned EXT_BASE    = DEF_EXT_BASE,
  parameter int unsigned EXT_SIZE    = DEF_EXT_SIZE,
  parameter int unsigned FIFO_BASE   = DEF_FIFO_BASE,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              CCLK,
  input  logic              RESET_n,
  input  logic              REGSPACE,
  input  logic              SBSELECT,
  input  logic              SBREAD_n,
  input  logic [ADDR_W-1:0] A,
  input  logic              EXT_ACK,
  output logic [NREG-1:0]   REG_RD_n,
  output logic [NREG-1:0]   REG_WR_n,
  output logic              FIFOREG_RD_n,
  output logic              FIFOREG_WR_n,
  output logic [1:0]        FIFOREG_SEL,
  output logic              EXT_RD_n,
  output logic              EXT_WR_n,
  output logic              DTACK_REQ_n,
  output logic              BERR_REQ_n,
  output logic              BUSY
);

  localparam int unsigned CNT_MAX = (TIMEOUT > WAIT_STATES) ? TIMEOUT : WAIT_STATES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic              sel_in;
  region_t           dec_region;
  logic [1:0]        dec_index;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              armed_q, armed_d;
  logic              sel_q, ext_ack_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  region_t           region_q, region_d;
  logic [1:0]        fsel_q, fsel_d;

  logic [NREG-1:0]   reg_rd_n_q, reg_rd_n_d;
  logic [NREG-1:0]   reg_wr_n_q, reg_wr_n_d;
  logic              fifo_rd_n_q, fifo_rd_n_d;
  logic              fifo_wr_n_q, fifo_wr_n_d;
  logic              ext_rd_n_q, ext_rd_n_d;
  logic              ext_wr_n_q, ext_wr_n_d;
  logic              dtack_n_q, dtack_n_d;
  logic              berr_n_q, berr_n_d;
  logic              busy_q, busy_d;
  logic              in_strobe;
  logic              min_done;
  logic              got_ack;

  assign sel_in = REGSPACE & SBSELECT;

  breg_region_dec #(
    .ADDR_W    (ADDR_W),
    .NREG      (NREG),
    .EXT_BASE  (EXT_BASE),
    .EXT_SIZE  (EXT_SIZE),
    .FIFO_BASE (FIFO_BASE)
  ) u_dec (
    .addr   (A),
    .region (dec_region),
    .index  (dec_index)
  );

  assign min_done = (cnt_q >= CNT_W'(WAIT_STATES));
  assign got_ack  = ack_q | ext_ack_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    armed_d  = armed_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    region_d = region_q;
    fsel_d   = fsel_q;
    case (state_q)
      IDLE: begin
        // Arming uses the live select so a SEL held through reset never starts.
        if (!sel_in) begin
          armed_d = 1'b1;
        end
        if (sel_q && armed_q) begin
          state_d = LATCH;
          armed_d = 1'b0;
        end
      end
      LATCH: begin
        addr_d   = A;
        wr_d     = SBREAD_n;
        region_d = dec_region;
        fsel_d   = dec_index;
        cnt_d    = CNT_W'(1);
        ack_d    = 1'b0;
        if (!sel_q)
          state_d = IDLE;
        else if (dec_region == UNMAPPED)
          state_d = ERR;
        else
          state_d = STROBE;
      end
      STROBE: begin
        if (!sel_q) begin
          state_d = IDLE;
        end else if (region_q == LOCAL) begin
          if (min_done)
            state_d = ACK;
          else
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
          if (min_done && got_ack) begin
            state_d = ACK;
          end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            ack_d = got_ack;
          end
        end
      end
      ACK, ERR: begin
        if (!sel_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_comb begin
    in_strobe   = (state_d == STROBE);
    reg_rd_n_d  = '1;
    reg_wr_n_d  = '1;
    for (int i = 0; i < NREG; i++) begin
      if (in_strobe && region_d == LOCAL && addr_d == ADDR_W'(i)) begin
        reg_rd_n_d[i] = wr_d;
        reg_wr_n_d[i] = !wr_d;
      end
    end
    fifo_rd_n_d = !(in_strobe && region_d == FIFO && !wr_d);
    fifo_wr_n_d = !(in_strobe && region_d == FIFO && wr_d);
    ext_rd_n_d  = !(in_strobe && region_d == EXT && !wr_d);
    ext_wr_n_d  = !(in_strobe && region_d == EXT && wr_d);
    dtack_n_d   = (state_d != ACK);
    berr_n_d    = (state_d != ERR);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge CCLK) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      armed_q     <= 1'b0;
      sel_q       <= 1'b0;
      ext_ack_q   <= 1'b0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      region_q    <= LOCAL;
      fsel_q      <= 2'd0;
      reg_rd_n_q  <= '1;
      reg_wr_n_q  <= '1;
      fifo_rd_n_q <= 1'b1;
      fifo_wr_n_q <= 1'b1;
      ext_rd_n_q  <= 1'b1;
      ext_wr_n_q  <= 1'b1;
      dtack_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      armed_q     <= armed_d;
      sel_q       <= sel_in;
      ext_ack_q   <= EXT_ACK;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      region_q    <= region_d;
      fsel_q      <= fsel_d;
      reg_rd_n_q  <= reg_rd_n_d;
      reg_wr_n_q  <= reg_wr_n_d;
      fifo_rd_n_q <= fifo_rd_n_d;
      fifo_wr_n_q <= fifo_wr_n_d;
      ext_rd_n_q  <= ext_rd_n_d;
      ext_wr_n_q  <= ext_wr_n_d;
      dtack_n_q   <= dtack_n_d;
      berr_n_q    <= berr_n_d;
      busy_q      <= busy_d;
    end
  end

  assign REG_RD_n     = reg_rd_n_q;
  assign REG_WR_n     = reg_wr_n_q;
  assign FIFOREG_RD_n = fifo_rd_n_q;
  assign FIFOREG_WR_n = fifo_wr_n_q;
  assign FIFOREG_SEL  = fsel_q;
  assign EXT_RD_n     = ext_rd_n_q;
  assign EXT_WR_n     = ext_wr_n_q;
  assign DTACK_REQ_n  = dtack_n_q;
  assign BERR_REQ_n   = berr_n_q;
  assign BUSY         = busy_q;

endmodule

// File: doc/breg_decode_seq.md
Name: breg_decode_seq

Overview:
- Parametrised, clocked successor to the board register-space decoder.
- Decodes a bus-slave word address into local register read/write strobes, a FIFO-register window and an external window.
- Times strobes and DTACK with a counter-based FSM instead of a gate-delay chain.
- Adds bus-error reporting for unmapped or timed-out accesses.
- Sits between the bus-slave interface logic (REGSPACE/SBSELECT/SBREAD_n) and the board register banks, FIFO and sequencer.

Parameters:
- ADDR_W, 9: word-address width (bus A[10:2]).
- NREG, 16: local registers at word addresses 0..NREG-1; 1..64.
- EXT_BASE, 32: first word address of the external window.
- EXT_SIZE, 32: external window size in words.
- FIFO_BASE, 60: first of 4 FIFO-register words; must lie inside the external window, where it takes priority.
- WAIT_STATES, 3: strobe width in clocks; at least 1.
- TIMEOUT, 255: maximum clocks to wait for EXT_ACK.

Ports:
- CCLK  in  1  clock.
- RESET_n  in  1  synchronous active-low reset.
- REGSPACE  in  1  register space addressed.
- SBSELECT  in  1  slave selected.
- SBREAD_n  in  1  0 = read, 1 = write.
- A  in  ADDR_W  word address.
- EXT_ACK  in  1  external/FIFO target done.
- REG_RD_n  out  NREG  local read strobes, active low.
- REG_WR_n  out  NREG  local write strobes, active low.
- FIFOREG_RD_n  out  1  FIFO read strobe, active low.
- FIFOREG_WR_n  out  1  FIFO write strobe, active low.
- FIFOREG_SEL  out  2  FIFO register index.
- EXT_RD_n  out  1  external read strobe, active low.
- EXT_WR_n  out  1  external write strobe, active low.
- DTACK_REQ_n  out  1  acknowledge request, active low.
- BERR_REQ_n  out  1  bus-error request, active low.
- BUSY  out  1  access in progress.

Behaviour:
- SEL = REGSPACE & SBSELECT, sampled on CCLK.
- Reset (RESET_n low at a CCLK edge):
  - every *_n output goes to 1, FIFOREG_SEL to 0, BUSY to 0, FSM to IDLE, counters to 0.
  - Reset overrides any state, including mid-strobe.
- Decode, fixed priority:
  - FIFO when FIFO_BASE <= A < FIFO_BASE+4.
  - LOCAL when A < NREG.
  - EXT when EXT_BASE <= A < EXT_BASE+EXT_SIZE.
  - Otherwise UNMAPPED.
  - All comparisons are unsigned, ADDR_W bits wide.
- IDLE:
  - Moves to LATCH when SEL=1 and ARMED=1.
  - ARMED is set in IDLE whenever SEL=0.
  - An access therefore needs a SEL deassertion before it starts; SEL held high after reset does not trigger.
- LATCH (1 clock):
  - Registers A, direction, region and FIFOREG_SEL=A[1:0]; BUSY=1.
  - Next state is STROBE, or ERR for UNMAPPED.
  - A and SBREAD_n changes after LATCH are ignored.
- STROBE, LOCAL:
  - The one selected REG_RD_n[i] or REG_WR_n[i] is low for exactly WAIT_STATES clocks, then ACK.
- STROBE, EXT/FIFO:
  - The matching strobe stays low until EXT_ACK=1 is sampled, with a minimum of WAIT_STATES clocks.
  - On EXT_ACK: strobe high, go to ACK.
  - After TIMEOUT strobe clocks without EXT_ACK: strobe high, go to ERR.
  - An EXT_ACK seen before the WAIT_STATES minimum has elapsed is remembered.
- ACK: DTACK_REQ_n=0 until SEL=0, then IDLE next clock with BUSY=0.
- ERR: BERR_REQ_n=0 until SEL=0, then IDLE.
- Abort: SEL=0 in LATCH or STROBE releases all strobes on the next edge, goes to IDLE, and asserts neither DTACK nor BERR.
- Invariants:
  - At most one strobe is low in any cycle.
  - DTACK_REQ_n and BERR_REQ_n are never low together.
  - Strobes never overlap DTACK.
  - All outputs are registered, with no combinational path from inputs.
- Latency, LOCAL access: SEL rises at edge 0 → strobe low for edges 2..WAIT_STATES+1 → DTACK low from edge WAIT_STATES+2.

Decomposition:
- Package breg_pkg:
  - state enum {IDLE, LATCH, STROBE, ACK, ERR}.
  - region enum {LOCAL, FIFO, EXT, UNMAPPED}.
  - Default base/size constants.
  - Function region_of(addr).
- Sub-module breg_region_dec: combinational address→region/index decode. It is reused by the sequencer register block.
- FSM and counters live in breg_decode_seq.

Test Plan:
- Write local register:
  - Stimulus: SEL=1, SBREAD_n=1, A=5, WAIT_STATES=3.
  - Response: REG_WR_n[5]=0 edges 2–4, all others high, DTACK_REQ_n=0 from edge 5 until SEL drops, BUSY=0 one clock later.
- FIFO read with delayed ack:
  - Stimulus: read, A=62, EXT_ACK pulsed at edge 8.
  - Response: FIFOREG_SEL=2, FIFOREG_RD_n=0 edges 2–8, DTACK from edge 9.
- External timeout:
  - Stimulus: write, A=40, TIMEOUT=10, EXT_ACK never asserted.
  - Response: EXT_WR_n low for 10 clocks, then BERR_REQ_n=0, DTACK_REQ_n stays 1.
- Unmapped access:
  - Stimulus: A=20 with NREG=16.
  - Response: no strobe, BERR_REQ_n=0 from edge 2.
- Abort mid-strobe:
  - Stimulus: SEL dropped at edge 3 of a local write.
  - Response: strobe high at edge 4, no DTACK/BERR, next access accepted normally.
- Reset and re-arm:
  - Stimulus: RESET_n=0 during STROBE.
  - Response: all outputs idle on the next edge.
  - Stimulus: SEL held 1 through reset release.
  - Response: no access until SEL cycles 0→1.
